// File: rtl/ser_pkg.sv
// Shared types and helpers for the parametrised serializer.
// Imported by param_serializer and parity_calc.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a word, inverted for odd parity.
// Feeds the parity register captured at load.
module parity_calc
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_type,
  output logic                  parity
);

  assign parity = (^data) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with LSB/MSB order, parity,
// mid-word stall and zero-gap back-to-back reload.
module param_serializer
  import ser_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  ser_en,
  input  logic                  msb_first,
  input  logic                  par_type,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  state_t                state;
  state_t                nxt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic                  msb_q;
  logic                  par_q;
  logic                  par_new;
  logic                  last;
  logic                  load;
  logic                  adv;

  assign last = (cnt == LAST);

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .data    (P_DATA),
    .par_type(par_type),
    .parity  (par_new)
  );

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (ser_en) nxt = SHIFT;
      SHIFT: if (last && !ser_en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Last bit always leaves: reload on ser_en, else drop to idle.
  always_comb begin
    busy     = (state == SHIFT);
    ser_done = busy && last;
    load     = ser_en && (!busy || last);
    adv      = busy && !last && ser_en;
    par_bit  = par_q;
    ser_data = IDLE_LEVEL;
    if (busy)
      ser_data = msb_q ? sreg[DATA_WIDTH-1] : sreg[0];
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sreg  <= '0;
      cnt   <= '0;
      msb_q <= 1'b0;
      par_q <= 1'b0;
    end else if (load) begin
      sreg  <= P_DATA;
      cnt   <= '0;
      msb_q <= msb_first;
      par_q <= par_new;
    end else if (adv) begin
      sreg  <= msb_q ? (sreg << 1) : (sreg >> 1);
      cnt   <= cnt + 1'b1;
    end else if (busy && last) begin
      cnt   <= '0;
    end
  end

endmodule
